sd_ddr_writer: RTL and testbench
================================

// Module: sd_ddr_writer
// PURPOSE
// - Downstream of the SD single-block reader: takes its byte stream (mydata_o/myvalid_o) and packs
//   bytes into DATA_W-bit words.
// - Buffers packed words in a small FIFO and writes them sequentially into DDR3 through the MIG
//   native app interface.
// - Stores one full picture (default 1024x768 RGB565) starting at BASE_ADDR, then flags done.
// - All inputs are synchronous to ui_clk; CDC from the SD clock domain is handled upstream.
// PARAMETERS
// DATA_W       128         MIG app data width, multiple of 16
// ADDR_W       28          MIG app_addr width
// BASE_ADDR    28'd0       first DDR3 address of the picture
// ADDR_STEP    28'd8       app_addr increment per DATA_W word
// TOTAL_BYTES  32'd1572864 picture size in bytes; must be a multiple of DATA_W/8
// FIFO_DEPTH   8           word FIFO depth, power of 2
// PORTS
// ui_clk               in   1       MIG user clock; all logic on rising edge
// ui_clk_sync_rst      in   1       synchronous, active-high reset
// init_calib_complete  in   1       MIG calibration done
// start_i              in   1       one-cycle pulse: arm a new picture transfer
// byte_i               in   8       SD data byte
// byte_valid_i         in   1       byte_i qualifier, single-cycle pulses, no backpressure
// app_addr             out  ADDR_W  MIG command address
// app_cmd              out  3       MIG command, always 3'b000 (write)
// app_en               out  1       command valid
// app_rdy              in   1       command accepted when app_en & app_rdy
// app_wdf_data         out  DATA_W  write data
// app_wdf_wren         out  1       write data valid
// app_wdf_end          out  1       equals app_wdf_wren (one beat per burst)
// app_wdf_mask         out  DATA_W/8  always 0
// app_wdf_rdy          in   1       data accepted when app_wdf_wren & app_wdf_rdy
// busy_o               out  1       high from accepted start_i until done_o
// done_o               out  1       sticky; picture fully written
// overflow_o           out  1       sticky; a byte was dropped
// BEHAVIOUR
// - Reset: all outputs 0; app_addr=BASE_ADDR; FIFO empty; packer lane 0; FSM IDLE.
// - Reset mid-transfer deasserts app_en/app_wdf_wren at the next edge; outstanding MIG beats are abandoned.
// - FSM IDLE: start_i -> WAIT_CAL; clears done_o, overflow_o, counters; app_addr=BASE_ADDR.
// - FSM WAIT_CAL: init_calib_complete=1 -> RUN. Bytes are packed in WAIT_CAL and RUN, not in IDLE or DONE.
// - FSM RUN: when words_written == TOTAL_BYTES/(DATA_W/8) -> DONE.
// - FSM DONE: done_o=1, busy_o=0; start_i -> WAIT_CAL, starting a new transfer.
// - start_i outside IDLE/DONE is ignored. byte_valid_i outside WAIT_CAL/RUN is ignored.
// - Packer: byte n of a word goes to lane n: bits [8n+7:8n], n = 0..DATA_W/8-1.
// - On the last lane the packed word is pushed into the FIFO in the same cycle and the lane index
//   returns to 0.
// - Overflow: a last-lane byte arriving while the FIFO is full is dropped (lane not advanced) and
//   overflow_o is set.
// - Overflow with simultaneous push and pop: the push is allowed.
// - Write engine (RUN only, FIFO not empty):
//   - Presents the FIFO head on app_wdf_data with app_wdf_wren=1, and app_en=1 with app_addr.
//   - Command and data handshakes complete independently; each side drops its valid the cycle after
//     its own acceptance.
//   - When both sides have been accepted: pop the FIFO, app_addr += ADDR_STEP, words_written += 1.
//     The next word can be issued in the following cycle.
//   - Peak throughput: 1 word per cycle when app_rdy and app_wdf_rdy are held high.
// - Latency: byte completing a word -> app_wdf_wren high 1 cycle later when the FIFO was empty and
//   the FSM is in RUN.
// - Arithmetic: app_addr wraps modulo 2^ADDR_W (no saturation). words_written is 32-bit.
// CONFIGURATION
// - SD_DDR_WRITER_SWAP_EN defined: each 16-bit pixel is byte-swapped before the FIFO push
//   (lane 2k <-> lane 2k+1), so big-endian RGB565 from the card lands little-endian in DDR3.
// - SD_DDR_WRITER_SWAP_EN undefined: lanes are stored as received.
// TESTING
// - Reset then start_i, calib=1, rdy=1; send bytes 0x00..0x0F.
//   -> one write at BASE_ADDR, app_wdf_data=128'h0F0E..0100, app_wdf_end=1.
// - Same stimulus with SD_DDR_WRITER_SWAP_EN defined.
//   -> app_wdf_data=128'h0E0F..0001.
// - calib=0 while 3 full words arrive, then calib=1.
//   -> 3 writes at BASE, BASE+8, BASE+16, in order.
// - app_rdy=0 for 5 cycles with app_wdf_rdy=1.
//   -> data accepted once, app_en held; FIFO pops only after the command is accepted.
// - FIFO_DEPTH=8, app_wdf_rdy=0, stream 9 words + 1 byte.
//   -> overflow_o=1 on the final word's last byte; exactly 8 words later written.
// - TOTAL_BYTES=64, full stream.
//   -> 4 writes, done_o=1 after the 4th dual acceptance; extra bytes ignored.
//   -> start_i restarts at BASE_ADDR.

Source files
------------

// File: rtl/sd_ddr_writer.sv
// -----------------------------------------------------------------------------
// sd_ddr_writer
// Packs the SD reader byte stream into DATA_W-bit words, buffers them in a
// small FIFO and writes them sequentially into DDR3 through the MIG native
// app interface. One picture of TOTAL_BYTES bytes is stored from BASE_ADDR
// upward, after which done_o is raised.
//
// Build option: define SD_DDR_WRITER_SWAP_EN to byte-swap every 16-bit pixel
// (lane 2k <-> lane 2k+1) before it enters the FIFO. Undefined: lanes are
// stored exactly as received.
//
// Ports (all synchronous to ui_clk, rising edge):
//   ui_clk_sync_rst      synchronous active-high reset
//   init_calib_complete  MIG calibration done
//   start_i              one-cycle pulse, arms a picture transfer
//   byte_i/byte_valid_i  SD byte stream, no backpressure
//   app_addr/app_cmd/app_en/app_rdy                MIG command channel
//   app_wdf_data/_wren/_end/_mask/app_wdf_rdy      MIG write-data channel
//   busy_o               transfer armed and not yet finished
//   done_o               sticky, whole picture written
//   overflow_o           sticky, a byte was dropped on a full FIFO
//
// FSM states:
//   S_IDLE     | after reset, waiting for start_i
//   S_WAIT_CAL | transfer armed, packing bytes, waiting for MIG calibration
//   S_RUN      | packing bytes and draining the FIFO into DDR3
//   S_DONE     | picture written, waiting for start_i to begin another
// -----------------------------------------------------------------------------
module sd_ddr_writer #(
  parameter int                DATA_W      = 128,
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(8),
  parameter logic [31:0]       TOTAL_BYTES = 32'd1572864,
  parameter int                FIFO_DEPTH  = 8
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic                  init_calib_complete,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DATA_W-1:0]     app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_rdy,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int          LANES       = DATA_W / 8;
  localparam int          LANE_W      = $clog2(LANES);
  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] TOTAL_WORDS = TOTAL_BYTES / 32'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_CAL, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // The last lane is never stored here: it goes straight into the FIFO word.
  logic [DATA_W-9:0]   r_pack;
  logic [LANE_W-1:0]   r_lane;

  logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_words;
  logic                r_cmd_done;
  logic                r_dat_done;
  logic                r_ovf;

  logic                w_start;
  logic                w_packing;
  logic                w_empty;
  logic                w_full;
  logic                w_engine;
  logic                w_cmd_acc;
  logic                w_dat_acc;
  logic                w_pop;
  logic                w_last_byte;
  logic                w_push;
  logic                w_drop;
  logic [DATA_W-1:0]   w_raw;
  logic [DATA_W-1:0]   w_word;

  assign w_start     = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_packing   = (r_state == S_WAIT_CAL) || (r_state == S_RUN);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  // Once the last word is counted the engine stops, even if stray words
  // are still queued behind it.
  assign w_engine    = (r_state == S_RUN) && !w_empty && (r_words != TOTAL_WORDS);
  assign w_cmd_acc   = app_en && app_rdy;
  assign w_dat_acc   = app_wdf_wren && app_wdf_rdy;
  assign w_pop       = w_engine && (r_cmd_done || w_cmd_acc) && (r_dat_done || w_dat_acc);
  assign w_last_byte = w_packing && byte_valid_i && (r_lane == LANE_W'(LANES-1));
  // A pop in the same cycle frees a slot, so a full FIFO can still take the word.
  assign w_push      = w_last_byte && (!w_full || w_pop);
  assign w_drop      = w_last_byte && !w_push;

  always_comb begin
    w_raw  = {byte_i, r_pack};
    w_word = w_raw;
`ifdef SD_DDR_WRITER_SWAP_EN
    for (int k = 0; k < LANES/2; k++) begin
      w_word[16*k +: 8]   = w_raw[16*k+8 +: 8];
      w_word[16*k+8 +: 8] = w_raw[16*k +: 8];
    end
`endif
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_nxt = S_WAIT_CAL;
      end
      S_WAIT_CAL: begin
        busy_o = 1'b1;
        if (init_calib_complete) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy_o       = 1'b1;
        app_en       = w_engine && !r_cmd_done;
        app_wdf_wren = w_engine && !r_dat_done;
        if (r_words == TOTAL_WORDS) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) w_state_nxt = S_WAIT_CAL;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; only the pointers define its contents.
  always_ff @(posedge ui_clk) begin
    if (w_push && !ui_clk_sync_rst && !w_start) r_fifo[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst || w_start) begin
      r_pack     <= '0;
      r_lane     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_addr     <= BASE_ADDR;
      r_words    <= '0;
      r_cmd_done <= 1'b0;
      r_dat_done <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_packing && byte_valid_i) begin
        if (w_last_byte) begin
          if (w_push) r_lane <= '0;
        end else begin
          r_pack[8*r_lane +: 8] <= byte_i;
          r_lane                <= r_lane + LANE_W'(1);
        end
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);

      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_addr     <= r_addr + ADDR_STEP;
        r_words    <= r_words + 32'd1;
        r_cmd_done <= 1'b0;
        r_dat_done <= 1'b0;
      end else begin
        if (w_cmd_acc) r_cmd_done <= 1'b1;
        if (w_dat_acc) r_dat_done <= 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign app_addr     = r_addr;
  assign app_cmd      = 3'b000;
  assign app_wdf_data = r_fifo[r_rd_ptr];
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_sd_ddr_writer.sv
module tb_sd_ddr_writer;

  localparam int          DW    = 128;
  localparam int          AW    = 28;
  localparam logic [27:0] BASE  = 28'hFFFFFF0;
  localparam logic [27:0] STEP  = 28'd8;
  localparam int          NW    = 8;
  localparam int          DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          calib = 1'b1;
  logic          start_i = 1'b0;
  logic [7:0]    byte_i = '0;
  logic          byte_valid_i = 1'b0;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic          app_wdf_rdy;
  logic          busy_o, done_o, overflow_o;

  logic fix_app_rdy = 1'b1, fix_wdf_rdy = 1'b1, rand_rdy = 1'b0;
  logic rnd_app = 1'b1, rnd_wdf = 1'b1;
  assign app_rdy     = rand_rdy ? rnd_app : fix_app_rdy;
  assign app_wdf_rdy = rand_rdy ? rnd_wdf : fix_wdf_rdy;

  sd_ddr_writer #(
    .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .ADDR_STEP(STEP),
    .TOTAL_BYTES(32'd128), .FIFO_DEPTH(DEPTH)
  ) dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib),
    .start_i(start_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_app = ($urandom_range(0, 3) != 0);
    rnd_wdf = ($urandom_range(0, 3) != 0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 armed waiting calibration, 2 running, 3 done
  int           m_phase = 0;
  logic [127:0] m_q[$];
  int           m_lane = 0;
  logic [127:0] m_part = '0;
  int           m_words = 0;
  bit           m_ovf = 0, m_cs = 0, m_ds = 0, m_init = 0;
  int           n_writes = 0;
  int           n_dacc = 0;
  logic [27:0]  log_addr[$];

  function automatic logic [127:0] arrange(input logic [127:0] w);
    logic [127:0] r;
    r = w;
`ifdef SD_DDR_WRITER_SWAP_EN
    for (int k = 0; k < 8; k++) begin
      r[16*k +: 8]   = w[16*k+8 +: 8];
      r[16*k+8 +: 8] = w[16*k +: 8];
    end
`endif
    return r;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_lane = 0; m_part = '0; m_words = 0;
    m_ovf = 0; m_cs = 0; m_ds = 0;
  endtask

  always @(negedge clk) begin
    bit act, e_en, e_wr, cacc, dacc, pop;
    int wb;
    logic [27:0] e_addr;
    if (app_en && app_rdy) log_addr.push_back(app_addr);
    if (app_wdf_wren && app_wdf_rdy) n_dacc++;
    act  = (m_phase == 2) && (m_words < NW) && (m_q.size() > 0);
    e_en = act && !m_cs;
    e_wr = act && !m_ds;
    if (m_init) begin
      chk("app_en", app_en, e_en);
      chk("app_wdf_wren", app_wdf_wren, e_wr);
      chk("app_wdf_end", app_wdf_end, e_wr);
      chk("app_cmd", app_cmd, 3'b000);
      chk("app_wdf_mask", app_wdf_mask, '0);
      chk("busy_o", busy_o, (m_phase == 1 || m_phase == 2));
      chk("done_o", done_o, (m_phase == 3));
      chk("overflow_o", overflow_o, m_ovf);
      if (act) begin
        e_addr = BASE + 28'(m_words * 8);
        if (e_en) chk("app_addr", app_addr, e_addr);
        if (e_wr) chk("app_wdf_data", app_wdf_data, m_q[0]);
      end
    end
    if (rst) begin
      m_phase = 0;
      model_clear();
      m_init = 1;
    end else if (m_init) begin
      wb   = m_words;
      cacc = e_en && app_rdy;
      dacc = e_wr && app_wdf_rdy;
      pop  = act && (m_cs || cacc) && (m_ds || dacc);
      if (pop) begin
        void'(m_q.pop_front());
        m_words++; m_cs = 0; m_ds = 0; n_writes++;
      end else begin
        m_cs = m_cs | cacc;
        m_ds = m_ds | dacc;
      end
      if ((m_phase == 1 || m_phase == 2) && byte_valid_i) begin
        if (m_lane < 15) begin
          m_part[8*m_lane +: 8] = byte_i;
          m_lane++;
        end else if (m_q.size() < DEPTH) begin
          m_part[127:120] = byte_i;
          m_q.push_back(arrange(m_part));
          m_lane = 0;
        end else begin
          m_ovf = 1;
        end
      end
      case (m_phase)
        0: if (start_i) begin model_clear(); m_phase = 1; end
        1: if (calib) m_phase = 2;
        2: if (wb == NW) m_phase = 3;
        default: if (start_i) begin model_clear(); m_phase = 1; end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid_i = 1'b1; byte_i = b;
    tick();
    byte_valid_i = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input bit gaps);
    for (int i = 0; i < 16; i++)
      send_byte(8'($urandom), gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (!done_o && k < maxc) begin tick(); k++; end
    chk("wait_done", done_o, 1'b1);
  endtask

  initial begin
    int w0, d0, l0;
    logic [127:0] exp1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_addr", app_addr, 28'hFFFFFF0);

    // first word 00..0F, check single-cycle latency and packing literal
    tick();
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    @(negedge clk); #1;
`ifdef SD_DDR_WRITER_SWAP_EN
    exp1 = 128'h0E0F0C0D0A0B08090607040502030001;
`else
    exp1 = 128'h0F0E0D0C0B0A09080706050403020100;
`endif
    chk("t1_wren", app_wdf_wren, 1'b1);
    chk("t1_end", app_wdf_end, 1'b1);
    chk("t1_data", app_wdf_data, exp1);
    chk("t1_addr", app_addr, 28'hFFFFFF0);
    tick();
    rand_rdy = 1'b1;
    for (int w = 0; w < 7; w++) send_word(1);
    wait_done(2000);
    rand_rdy = 1'b0;
    chk("t1_writes", n_writes, 8);
    chk("t1_busy", busy_o, 1'b0);

    // bytes after completion are ignored
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 0);
    repeat (3) tick();
    chk("t2_writes", n_writes, 8);
    chk("t2_done", done_o, 1'b1);

    // words collected while calibration is low, then drained in order
    calib = 1'b0;
    pulse_start();
    for (int w = 0; w < 3; w++) send_word(0);
    repeat (5) tick();
    chk("t3_no_en", app_en, 1'b0);
    chk("t3_writes_held", n_writes, 8);
    l0 = log_addr.size();
    calib = 1'b1;
    begin
      int k = 0;
      while (log_addr.size() < l0 + 3 && k < 50) begin tick(); k++; end
    end
    chk("t3_count", log_addr.size() >= l0 + 3, 1'b1);
    if (log_addr.size() >= l0 + 3) begin
      chk("t3_addr0", log_addr[l0],   28'hFFFFFF0);
      chk("t3_addr1", log_addr[l0+1], 28'hFFFFFF8);
      chk("t3_addr2", log_addr[l0+2], 28'h0000000);
    end
    for (int w = 0; w < 5; w++) send_word(1);
    wait_done(2000);

    // command side stalled, data side ready
    fix_app_rdy = 1'b0;
    pulse_start();
    w0 = n_writes;
    send_word(0);
    d0 = n_dacc;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("t4_en_held", app_en, 1'b1);
      tick();
    end
    chk("t4_data_once", n_dacc - d0, 1);
    chk("t4_no_pop", n_writes - w0, 0);
    fix_app_rdy = 1'b1;
    repeat (2) tick();
    chk("t4_pop", n_writes - w0, 1);
    for (int w = 0; w < 7; w++) send_word(0);
    wait_done(2000);

    // overflow: data side stalled, 9 words + 1 byte
    fix_wdf_rdy = 1'b0;
    pulse_start();
    w0 = n_writes;
    for (int i = 0; i < 143; i++) send_byte(8'($urandom), 0);
    @(negedge clk); #1;
    chk("t5_ovf_before", overflow_o, 1'b0);
    tick();
    send_byte(8'hA5, 0);
    @(negedge clk); #1;
    chk("t5_ovf_set", overflow_o, 1'b1);
    tick();
    send_byte(8'h5A, 0);
    fix_wdf_rdy = 1'b1;
    wait_done(500);
    chk("t5_writes", n_writes - w0, 8);
    chk("t5_ovf_sticky", overflow_o, 1'b1);

    // reset in the middle of a stalled write
    fix_app_rdy = 1'b0; fix_wdf_rdy = 1'b0;
    pulse_start();
    chk("t6_ovf_cleared", overflow_o, 1'b0);
    send_word(0);
    @(negedge clk); #1;
    chk("t6_en_before", app_en, 1'b1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_en_after", app_en, 1'b0);
    chk("t6_wren_after", app_wdf_wren, 1'b0);
    chk("t6_busy_after", busy_o, 1'b0);
    chk("t6_addr_after", app_addr, 28'hFFFFFF0);
    tick();
    fix_app_rdy = 1'b1; fix_wdf_rdy = 1'b1;

    // random handshakes, a start ignored mid-transfer, then restart
    rand_rdy = 1'b1;
    for (int t = 0; t < 2; t++) begin
      l0 = log_addr.size();
      pulse_start();
      for (int w = 0; w < 8; w++) begin
        send_word(1);
        if (w == 3) pulse_start();
      end
      wait_done(3000);
      chk("t7_first_addr", (log_addr.size() > l0) ? log_addr[l0] : 28'hABCDEF1, 28'hFFFFFF0);
    end
    rand_rdy = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
